// File: rtl/irq_pkg.sv
// Shared types and constants for the machine-mode interrupt controller:
// FSM state encoding, default sizing, mcause interrupt bit and trap-flow CSR addresses.
package irq_pkg;

  localparam int NUM_IRQ_DEF    = 6;
  localparam int CAUSE_BASE_DEF = 16;

  localparam int          MCAUSE_INT_BIT = 31;
  localparam logic [31:0] MCAUSE_INT     = 32'h1 << MCAUSE_INT_BIT;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_JUMP    = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins; outputs valid, index and one-hot grant.
module irq_prio_enc #(
  parameter int N     = 6,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     grant_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    grant_o = '0;
    // Scan high to low so the lowest requesting index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o      = IDX_W'(i);
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: prioritises masked requests and sequences trap entry/return.
// Define IRQ_CTRL_EDGE_EN for rising-edge capture of requests; default is level-sensitive.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ    = NUM_IRQ_DEF,
  parameter int CAUSE_BASE = CAUSE_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mie,
  input  logic [31:0]        mtvec,
  input  logic [31:0]        mepc,
  input  logic               en_int_rst,
  input  logic [31:0]        pc,
  input  logic               boundary_i,
  input  logic               mret_i,
  output logic               en_mepc,
  output logic [31:0]        mepc_csr,
  output logic               en_cause,
  output logic [31:0]        mcause,
  output logic               stall_o,
  output logic               pc_sel_o,
  output logic [31:0]        pc_target_o,
  output logic [NUM_IRQ-1:0] int_ack_o,
  output logic               busy_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_IRQ-1:0] grant_q, grant_d;
  logic [31:0]        pc_q, pc_d;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_idx;
  logic [NUM_IRQ-1:0] enc_grant;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;

  // A fresh edge in the ack cycle must survive the ack, hence OR after the clear.
  always_comb pending_d = (pending_q & ~int_ack_o) | (irq_i & ~irq_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = irq_i;
`endif

  assign eligible = pending & mie;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req_i   (eligible),
    .valid_o (enc_valid),
    .idx_o   (enc_idx),
    .grant_o (enc_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      grant_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    grant_d     = grant_q;
    pc_d        = pc_q;
    en_mepc     = 1'b0;
    mepc_csr    = '0;
    en_cause    = 1'b0;
    mcause      = '0;
    stall_o     = 1'b0;
    pc_sel_o    = 1'b0;
    pc_target_o = '0;
    int_ack_o   = '0;
    busy_o      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Winner and return PC are frozen here so later mie/pc changes cannot alter the trap.
        if (boundary_i && enc_valid && !en_int_rst) begin
          state_d = ST_SAVE;
          idx_d   = enc_idx;
          grant_d = enc_grant;
          pc_d    = pc;
        end
      end
      ST_SAVE: begin
        busy_o   = 1'b1;
        stall_o  = 1'b1;
        en_mepc  = 1'b1;
        mepc_csr = pc_q;
        en_cause = 1'b1;
        mcause   = MCAUSE_INT | {1'b0, 31'(CAUSE_BASE) + 31'(idx_q)};
        state_d  = ST_JUMP;
      end
      ST_JUMP: begin
        busy_o      = 1'b1;
        stall_o     = 1'b1;
        pc_sel_o    = 1'b1;
        pc_target_o = mtvec;
        int_ack_o   = grant_q;
        state_d     = ST_HANDLER;
      end
      ST_HANDLER: begin
        busy_o = 1'b1;
        if (mret_i) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        busy_o      = 1'b1;
        pc_sel_o    = 1'b1;
        pc_target_o = mepc;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: vector table for entry/priority/return, hand sequences for corners.
module tb_irq_controller;

  localparam logic [31:0] MTVEC = 32'h0000_0800;
  localparam logic [31:0] MEPC  = 32'h0000_0104;

  typedef struct packed {
    logic        busy;
    logic        en_mepc;
    logic [31:0] mepc_csr;
    logic        en_cause;
    logic [31:0] mcause;
    logic        stall;
    logic        pc_sel;
    logic [31:0] target;
    logic [5:0]  ack;
  } out_t;

  typedef struct {
    logic [5:0]  irq;
    logic [5:0]  mie;
    logic        bnd;
    logic        mret;
    logic [31:0] pc;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  irq_i, mie, int_ack_o;
  logic [31:0] mtvec, mepc, pc, mepc_csr, mcause, pc_target_o;
  logic        en_int_rst, boundary_i, mret_i;
  logic        en_mepc, en_cause, stall_o, pc_sel_o, busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq_i),
    .mie         (mie),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .en_int_rst  (en_int_rst),
    .pc          (pc),
    .boundary_i  (boundary_i),
    .mret_i      (mret_i),
    .en_mepc     (en_mepc),
    .mepc_csr    (mepc_csr),
    .en_cause    (en_cause),
    .mcause      (mcause),
    .stall_o     (stall_o),
    .pc_sel_o    (pc_sel_o),
    .pc_target_o (pc_target_o),
    .int_ack_o   (int_ack_o),
    .busy_o      (busy_o)
  );

  function automatic out_t o_idle();
    return '0;
  endfunction

  function automatic out_t o_save(input logic [31:0] p, input logic [31:0] c);
    out_t o = '0;
    o.busy = 1'b1; o.stall = 1'b1;
    o.en_mepc = 1'b1; o.mepc_csr = p;
    o.en_cause = 1'b1; o.mcause = c;
    return o;
  endfunction

  function automatic out_t o_jump(input logic [5:0] a);
    out_t o = '0;
    o.busy = 1'b1; o.stall = 1'b1; o.pc_sel = 1'b1; o.target = MTVEC; o.ack = a;
    return o;
  endfunction

  function automatic out_t o_hand();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t o_ret();
    out_t o = '0;
    o.busy = 1'b1; o.pc_sel = 1'b1; o.target = MEPC;
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t a;
    a = {busy_o, en_mepc, mepc_csr, en_cause, mcause, stall_o, pc_sel_o, pc_target_o, int_ack_o};
    total++;
    if (a === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, a, exp);
  endtask

  task automatic chk_zero(input string name, input int cnt);
    total++;
    if (cnt == 0) passed++;
    else $display("FAIL %s: got %0d busy cycles expected 0", name, cnt);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [5:0] irq, input logic [5:0] m, input logic b,
                       input logic r, input logic [31:0] p, input logic en);
    @(negedge clk);
    irq_i = irq; mie = m; boundary_i = b; mret_i = r; pc = p; en_int_rst = en;
    #1;
  endtask

  vec_t vt[24];
  int   bad;

  initial begin
    vt[0]  = '{6'b000000, 6'b000100, 1'b0, 1'b0, 32'h0,   o_idle()};
    vt[1]  = '{6'b000100, 6'b000100, 1'b0, 1'b0, 32'h0,   o_idle()};
    vt[2]  = '{6'b000100, 6'b000100, 1'b1, 1'b0, 32'h100, o_idle()};
    vt[3]  = '{6'b000100, 6'b000100, 1'b0, 1'b0, 32'h0,   o_save(32'h100, 32'h8000_0012)};
    vt[4]  = '{6'b000100, 6'b000100, 1'b0, 1'b0, 32'h0,   o_jump(6'b000100)};
    vt[5]  = '{6'b000000, 6'b000100, 1'b0, 1'b0, 32'h0,   o_hand()};
    vt[6]  = '{6'b000000, 6'b000100, 1'b1, 1'b0, 32'h0,   o_hand()};
    vt[7]  = '{6'b000000, 6'b000100, 1'b0, 1'b1, 32'h0,   o_hand()};
    vt[8]  = '{6'b000000, 6'b000100, 1'b0, 1'b0, 32'h0,   o_ret()};
    vt[9]  = '{6'b000000, 6'b000100, 1'b0, 1'b0, 32'h0,   o_idle()};
    vt[10] = '{6'b101000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_idle()};
    vt[11] = '{6'b101000, 6'b111111, 1'b1, 1'b0, 32'h200, o_idle()};
    vt[12] = '{6'b101000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_save(32'h200, 32'h8000_0013)};
    vt[13] = '{6'b101000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_jump(6'b001000)};
    vt[14] = '{6'b100000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_hand()};
    vt[15] = '{6'b100000, 6'b111111, 1'b0, 1'b1, 32'h0,   o_hand()};
    vt[16] = '{6'b100000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_ret()};
    vt[17] = '{6'b100000, 6'b111111, 1'b1, 1'b0, 32'h300, o_idle()};
    vt[18] = '{6'b100000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_save(32'h300, 32'h8000_0015)};
    vt[19] = '{6'b100000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_jump(6'b100000)};
    vt[20] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_hand()};
    vt[21] = '{6'b000000, 6'b111111, 1'b0, 1'b1, 32'h0,   o_hand()};
    vt[22] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_ret()};
    vt[23] = '{6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0,   o_idle()};

    rst_n = 1'b0; irq_i = '0; mie = '0; boundary_i = 1'b0; mret_i = 1'b0;
    pc = '0; en_int_rst = 1'b0; mtvec = MTVEC; mepc = MEPC;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset", o_idle());
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].irq, vt[i].mie, vt[i].bnd, vt[i].mret, vt[i].pc, 1'b0);
      chk($sformatf("vec%0d", i), vt[i].exp);
    end

    // Masked source never traps; unmasking takes it at the next boundary.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      drive(6'b000001, 6'b000000, 1'b1, 1'b0, 32'h400, 1'b0);
      if (busy_o !== 1'b0) bad++;
    end
    chk_zero("mie0_no_busy", bad);
    drive(6'b000001, 6'b000001, 1'b1, 1'b0, 32'h400, 1'b0); chk("mie_set_idle", o_idle());
    drive(6'b000001, 6'b000001, 1'b0, 1'b0, 32'h0,   1'b0); chk("mie_set_save", o_save(32'h400, 32'h8000_0010));
    drive(6'b000001, 6'b000001, 1'b0, 1'b0, 32'h0,   1'b0); chk("mie_set_jump", o_jump(6'b000001));
    drive(6'b000000, 6'b000001, 1'b0, 1'b1, 32'h0,   1'b0); chk("mie_set_hand", o_hand());
    drive(6'b000000, 6'b000001, 1'b0, 1'b0, 32'h0,   1'b0); chk("mie_set_ret",  o_ret());
    drive(6'b000000, 6'b000001, 1'b0, 1'b0, 32'h0,   1'b0); chk("mie_set_back", o_idle());

    // CSR-uninitialised inhibit, then nested request in HANDLER and reset mid-SAVE.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(6'b000010, 6'b111111, 1'b1, 1'b0, 32'h500, 1'b1);
      if (busy_o !== 1'b0) bad++;
    end
    chk_zero("eir_inhibit", bad);
    drive(6'b000010, 6'b111111, 1'b1, 1'b0, 32'h500, 1'b0); chk("eir_release", o_idle());
    drive(6'b000010, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("eir_save", o_save(32'h500, 32'h8000_0011));
    drive(6'b000010, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("eir_jump", o_jump(6'b000010));
    drive(6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("eir_hand", o_hand());
    drive(6'b000010, 6'b111111, 1'b1, 1'b0, 32'h0,   1'b0); chk("no_nesting", o_hand());
    drive(6'b000010, 6'b111111, 1'b0, 1'b1, 32'h0,   1'b0); chk("nest_mret", o_hand());
    drive(6'b000010, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("nest_ret", o_ret());
    drive(6'b000010, 6'b111111, 1'b1, 1'b0, 32'h600, 1'b0); chk("nest_idle", o_idle());
    drive(6'b000010, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("nest_save", o_save(32'h600, 32'h8000_0011));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_save", o_idle());
    @(negedge clk);
    irq_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b000000, 6'b111111, 1'b0, 1'b1, 32'h0, 1'b0); chk("post_rst_idle", o_idle());
    drive(6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0, 1'b0); chk("mret_idle_ignored", o_idle());

`ifdef IRQ_CTRL_EDGE_EN
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("edge_rise", o_idle());
    drive(6'b010000, 6'b111111, 1'b1, 1'b0, 32'h700, 1'b0); chk("edge_bnd", o_idle());
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("edge_save", o_save(32'h700, 32'h8000_0014));
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("edge_jump", o_jump(6'b010000));
    drive(6'b010000, 6'b111111, 1'b0, 1'b1, 32'h0,   1'b0); chk("edge_hand", o_hand());
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("edge_ret", o_ret());
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(6'b010000, 6'b111111, 1'b1, 1'b0, 32'h0, 1'b0);
      if (busy_o !== 1'b0) bad++;
    end
    chk_zero("edge_held_once", bad);
    drive(6'b000000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0);
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0);
    drive(6'b010000, 6'b111111, 1'b1, 1'b0, 32'h800, 1'b0); chk("edge2_idle", o_idle());
    drive(6'b010000, 6'b111111, 1'b0, 1'b0, 32'h0,   1'b0); chk("edge2_save", o_save(32'h800, 32'h8000_0014));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Machine-mode interrupt controller for the RV32I core. It captures up to six external interrupt requests, masks them with `mie` from the CSR file, and selects the highest-priority one. It then sequences trap entry: it saves `mepc` and `mcause` through the CSR write-enables, redirects the PC to `mtvec`, and acknowledges the source. On `mret` it redirects the PC back to `mepc`. It sits between the interrupt sources, the CSR file and the PC mux.

## Interface
- `NUM_IRQ`, 6: number of interrupt sources; must match the `mie` width.
- `CAUSE_BASE`, 16: `mcause` code of source 0; source i reports `CAUSE_BASE+i`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_i`  in  NUM_IRQ  raw interrupt requests, already synchronous to `clk`.
- `mie`  in  NUM_IRQ  enable mask from the CSR file.
- `mtvec`  in  32  handler base address from the CSR file.
- `mepc`  in  32  saved return PC from the CSR file.
- `en_int_rst`  in  1  high while CSRs are uninitialised; inhibits trap entry.
- `pc`  in  32  address of the instruction about to issue.
- `boundary_i`  in  1  core is at an instruction boundary; interrupt may be taken.
- `mret_i`  in  1  one-cycle pulse when `mret` executes.
- `en_mepc`  out  1  `mepc` write-enable to the CSR file.
- `mepc_csr`  out  32  value written to `mepc`.
- `en_cause`  out  1  `mcause` write-enable.
- `mcause`  out  32  value written to `mcause`.
- `stall_o`  out  1  holds the core PC and fetch during trap entry.
- `pc_sel_o`  out  1  selects `pc_target_o` as the next PC.
- `pc_target_o`  out  32  redirect address.
- `int_ack_o`  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken source.
- `busy_o`  out  1  high from entry through return.

## Operation
- `eligible = pending & mie`. Priority is fixed: lowest index wins.
- FSM states are IDLE, SAVE, JUMP, HANDLER and RETURN.
- **IDLE**
  - Goes to SAVE when `boundary_i`, `|eligible` and `!en_int_rst` are all true.
  - On that transition it latches the winning index and `pc` into `pc_q`.
- **SAVE** (1 cycle)
  - `en_mepc=1`, `mepc_csr=pc_q`.
  - `en_cause=1`, `mcause={1'b1, 31'(CAUSE_BASE+idx)}`.
  - `stall_o=1`. Next state is JUMP.
- **JUMP** (1 cycle)
  - `pc_sel_o=1`, `pc_target_o=mtvec`, `stall_o=1`.
  - `int_ack_o[idx]=1`, which clears `pending[idx]`. Next state is HANDLER.
- **HANDLER**: no nesting. On `mret_i` the next state is RETURN.
- **RETURN** (1 cycle): `pc_sel_o=1`, `pc_target_o=mepc`. Next state is IDLE.
- `busy_o` is high in every state except IDLE.
- `mret_i` outside HANDLER is ignored.
- Requests arriving in any non-IDLE state stay pending and are evaluated in IDLE.
- Clearing a `mie` bit in IDLE drops that source from `eligible` immediately. Pending state is unaffected.
- Changing `mie` after entering SAVE does not change the latched `idx`.
- `en_int_rst` has effect only in IDLE.
- Outputs not listed for a state are 0. `mepc_csr`, `mcause` and `pc_target_o` read 0 when their enable or select is low.

## Timing
- Reset (asynchronous): state IDLE, `pending=0`, `pc_q=0`, `idx=0`, all outputs 0.
- Reset during any state returns to IDLE immediately. No partial CSR write persists beyond the reset cycle.
- Entry latency: the boundary cycle is cycle 0. SAVE strobes are in cycle 1; the redirect and ack are in cycle 2; the handler's first fetch is in cycle 3.
- Return latency: `mret_i` in cycle 0, redirect to `mepc` in cycle 1, back in IDLE in cycle 2.
- A back-to-back interrupt can be taken at the first `boundary_i` in IDLE, i.e. no earlier than cycle 2 after `mret_i`.
- Simultaneous new request and ack on the same source: the ack wins (in edge mode only the new edge re-pends).

## Configuration
- `IRQ_CTRL_EDGE_EN` defined:
  - Each source has an edge detector (`irq_q` register).
  - A rising edge sets `pending[i]`. `int_ack_o[i]` clears it; a simultaneous new edge keeps it set.
- `IRQ_CTRL_EDGE_EN` undefined:
  - Level-sensitive: `pending = irq_i` directly, with no `pending` or `irq_q` flops.
  - `int_ack_o` tells the source to drop its line.

## Structure
- Package `irq_pkg` holds:
  - the FSM state typedef (3-bit);
  - `NUM_IRQ` and `CAUSE_BASE` defaults;
  - the `mcause` interrupt-bit constant (bit 31);
  - the CSR addresses used by the trap flow: `mie` 12'h304, `mtvec` 12'h305, `mcause` 12'h342.
- One sub-module, `irq_prio_enc`, is natural: a parameterised fixed-priority encoder that outputs a valid flag, an index, and a one-hot grant.

## Test plan
- Reset, then `mie=6'b000100`, pulse `irq_i[2]`, `boundary_i` with `pc=0x100` → cycle 1: `en_mepc=1`, `mepc_csr=0x100`, `mcause=0x80000012`; cycle 2: `pc_target_o=mtvec`, `int_ack_o=6'b000100`.
- `irq_i=6'b101000`, `mie=6'b111111` → source 3 is taken (`mcause=0x80000013`); source 5 is taken after `mret_i` at the next boundary.
- `mie=0` with `irq_i[0]` high for 20 cycles → no `busy_o`. Then set `mie[0]` → entry at the next boundary.
- `en_int_rst=1` with an eligible request → stays IDLE. Deassert it → entry follows.
- In HANDLER, raise `irq_i[1]` and deassert `rst_n` mid-SAVE of a later entry → all outputs 0, state IDLE; `mret_i` while IDLE is ignored.
- With `IRQ_CTRL_EDGE_EN`: hold `irq_i[4]` high across ack → taken once only. A second rising edge → taken again.
